sys_arr_load_sequencer: RTL and testbench
=========================================

# sys_arr_load_sequencer

Hardware replacement for the bench-driven load path of the sparse systolic array. Accepts weight-tile and input-batch commands plus a row stream from an upstream buffer, and drives the array's memory-side load port (weight/input/partial enables, row select, values, column indices, end flags, partials). Flow control is gated on the array's `drained` and `fifo_has_space` status. The block is parametrised in array size, data width and weight-buffering mode, and counts completed output vectors.

## Interface
Parameters:
- `N`, 4: array dimension (rows per weight tile, max rows per input batch).
- `DW`, 32: value width.
- `IND`, `$clog2(N)`: column-index width.
- `DBUF`, 1: 1 = double-buffered weights (load early, gate next inputs on drain); 0 = gate the weight load itself on drain.
- `CW`, 16: output-counter width.

Ports:
- `clk` in 1: clock.
- `nRST` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_type` in 1: 0 = weights, 1 = inputs.
- `cmd_rows` in `$clog2(N)+1`: input rows in the batch (0..N); ignored for weights.
- `row_valid` in 1 / `row_ready` out 1: row-stream handshake.
- `row_vals` in N*DW, `row_inds` in N*IND, `row_ends` in N, `row_partials` in N*DW: row payload.
- `drained`, `fifo_has_space`, `out_en` in 1: array status.
- `weight_en`, `input_en`, `partial_en` out 1: array load strobes.
- `row_in_en` out `$clog2(N)`: weight row select.
- `vals_in` out N*DW, `inds_in` out N*IND, `ends_in` out N, `array_in_partials` out N*DW.
- `busy` out 1: state ≠ IDLE.
- `out_count` out CW: saturating count of `out_en` cycles.

## Operation
- States: IDLE, WAIT_DRAIN, WLOAD, WAIT_SPACE, ILOAD, IGAP, CGAP.
- `cmd_ready` = (state == IDLE). A command transfers when `cmd_valid && cmd_ready`.
- Weights command:
  - If `DBUF`=0 → WAIT_DRAIN until `drained`, then WLOAD.
  - If `DBUF`=1 → WLOAD directly.
  - WLOAD: `row_ready`=1. Each accepted row r (0..N-1) produces `weight_en`=1, `row_in_en`=r. After row N-1 → CGAP.
  - On completion sets `wpend` if `DBUF`=1.
- Inputs command:
  - If `wpend` → WAIT_DRAIN (until `drained`; clears `wpend`).
  - Otherwise → WAIT_SPACE (until `fifo_has_space`).
  - Then ILOAD.
  - ILOAD: `row_ready`=1. An accepted row issues `input_en`=1; the first row of the batch also issues `partial_en`=1 with `array_in_partials`=`row_partials`. Then IGAP (1 idle cycle), back to ILOAD until `cmd_rows` rows are issued, then CGAP.
  - `cmd_rows`=0 → CGAP directly, no strobes.
- CGAP: one idle cycle, then IDLE.
- No `row_valid` in WLOAD/ILOAD: hold state, strobes low.
- When no strobe is issued: `vals_in`, `array_in_partials`, `row_in_en` = 0; `inds_in`/`ends_in` hold their last value.
- `out_count` increments on every `out_en` cycle regardless of state and saturates at all-ones.

## Timing
- All array-side outputs are registered: a row accepted at edge k appears on outputs for exactly one cycle after edge k.
- Weight tile: N consecutive cycles with a continuous stream; CGAP adds 1. Command-to-command minimum is N+2 cycles.
- Input batch of R rows: 2R cycles in ILOAD/IGAP plus 1 CGAP, after the gate opens.
- `drained`/`fifo_has_space` are sampled in the wait state. A gate that is already true still costs one cycle in the wait state.
- Reset (any state): next state IDLE; `wpend`=0; `inds_in`/`ends_in`=0; `out_count`=0.
- All outputs read 0 in reset except `cmd_ready`, which is 1 (IDLE).
- `cmd_valid` while busy: ignored (not accepted) until IDLE.

## Structure
- `sys_arr_pkg` additions:
  - `seq_state_t` enum.
  - `cmd_type_t` enum (CMD_WEIGHTS=0, CMD_INPUTS=1).
  - Reuse the existing `N`, `DW`, `IND` constants as parameter defaults.
- One sub-module, `sat_counter` (CW-bit, enable, saturating), for `out_count`. All other logic stays flat.

## Test plan
- Reset: hold `nRST`=0 for 2 cycles mid-WLOAD → `cmd_ready`=1, all strobes 0, `out_count`=0, `wpend` cleared.
- `DBUF`=1, N=4, weights then 3-row inputs, `drained`=0 for 10 cycles:
  - `weight_en` asserts on 4 consecutive cycles with `row_in_en` 0,1,2,3.
  - No `input_en` until `drained`=1.
  - Then `input_en` on alternate cycles, 3 pulses; `partial_en` only on the first.
- `DBUF`=0: weights command with `drained`=0 → no `weight_en` until `drained`=1; then 4 consecutive pulses.
- Inputs with `fifo_has_space`=0 → stalls in WAIT_SPACE; raising it → first row issued 2 cycles later with partials `{4,3,2,1}` on `array_in_partials`.
- Row-stream bubble: drop `row_valid` for 3 cycles mid-WLOAD → strobes low, `row_in_en` resumes at the next index. `cmd_rows`=0 → returns to IDLE in 2 cycles with no strobes.
- `out_en` held for 2^CW+5 cycles with CW=4 → `out_count` saturates at 15.

Source files
------------

// File: rtl/sys_arr_pkg.sv
// Shared types and default sizing for the sparse systolic array and its load path.
//   N   : array dimension (rows per weight tile, max rows per input batch)
//   DW  : value width
//   IND : column-index width
//   seq_state_t : load-sequencer FSM states
//   cmd_type_t  : sequencer command type
package sys_arr_pkg;

  localparam int unsigned N   = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned IND = $clog2(N);

  typedef enum logic [2:0] {
    StIdle,
    StWaitDrain,
    StWload,
    StWaitSpace,
    StIload,
    StIgap,
    StCgap
  } seq_state_t;

  typedef enum logic {
    CMD_WEIGHTS = 1'b0,
    CMD_INPUTS  = 1'b1
  } cmd_type_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
//   clk_i   : clock
//   rst_ni  : synchronous active-low reset (clears the count)
//   en_i    : count enable, one increment per enabled cycle
//   count_o : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != '1)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sys_arr_load_sequencer.sv
// Load sequencer for the sparse systolic array. Takes weight-tile / input-batch commands and an
// upstream row stream, and drives the array's memory-side load port with registered strobes.
//   clk, nRST                : clock, synchronous active-low reset
//   cmd_valid/ready, type, rows : command handshake (type 0 weights, 1 inputs; rows for inputs)
//   row_valid/ready, row_*   : row stream handshake and payload
//   drained, fifo_has_space  : array status gating weight/input loads
//   out_en                   : array output strobe, counted into out_count
//   weight_en, input_en, partial_en, row_in_en, vals_in, inds_in, ends_in,
//   array_in_partials        : array load port (registered)
//   busy                     : FSM not idle
//   out_count                : saturating count of out_en cycles
module sys_arr_load_sequencer #(
  parameter int unsigned N    = sys_arr_pkg::N,
  parameter int unsigned DW   = sys_arr_pkg::DW,
  parameter int unsigned IND  = $clog2(N),
  parameter bit          DBUF = 1'b1,
  parameter int unsigned CW   = 16
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_type,
  input  logic [$clog2(N):0]    cmd_rows,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [N*DW-1:0]       row_vals,
  input  logic [N*IND-1:0]      row_inds,
  input  logic [N-1:0]          row_ends,
  input  logic [N*DW-1:0]       row_partials,
  input  logic                  drained,
  input  logic                  fifo_has_space,
  input  logic                  out_en,
  output logic                  weight_en,
  output logic                  input_en,
  output logic                  partial_en,
  output logic [$clog2(N)-1:0]  row_in_en,
  output logic [N*DW-1:0]       vals_in,
  output logic [N*IND-1:0]      inds_in,
  output logic [N-1:0]          ends_in,
  output logic [N*DW-1:0]       array_in_partials,
  output logic                  busy,
  output logic [CW-1:0]         out_count
);

  import sys_arr_pkg::*;

  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] LastRow = CntW'(N - 1);

  seq_state_t            state_q, state_d;
  cmd_type_t             type_q, type_d;
  logic                  wpend_q, wpend_d;
  logic [CntW-1:0]       rows_q, rows_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  weight_en_q, weight_en_d;
  logic                  input_en_q, input_en_d;
  logic                  partial_en_q, partial_en_d;
  logic [CntW-2:0]       row_in_en_q, row_in_en_d;
  logic [N*DW-1:0]       vals_q, vals_d;
  logic [N*IND-1:0]      inds_q, inds_d;
  logic [N-1:0]          ends_q, ends_d;
  logic [N*DW-1:0]       partials_q, partials_d;

  logic                  row_fire;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign row_ready = (state_q == StWload) || (state_q == StIload);
  assign row_fire  = row_valid && row_ready;

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    wpend_d      = wpend_q;
    rows_d       = rows_q;
    cnt_d        = cnt_q;
    weight_en_d  = 1'b0;
    input_en_d   = 1'b0;
    partial_en_d = 1'b0;
    row_in_en_d  = '0;
    vals_d       = '0;
    partials_d   = '0;
    // Index and end flags keep their last issued value between strobes.
    inds_d       = inds_q;
    ends_d       = ends_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          type_d = cmd_type_t'(cmd_type);
          rows_d = cmd_rows;
          cnt_d  = '0;
          if (cmd_type_t'(cmd_type) == CMD_WEIGHTS) begin
            // Double-buffered weights load immediately; otherwise wait for the array to drain.
            state_d = DBUF ? StWload : StWaitDrain;
          end else if (cmd_rows == '0) begin
            state_d = StCgap;
          end else if (wpend_q) begin
            // A freshly loaded tile is only live once the previous batch has drained.
            state_d = StWaitDrain;
          end else begin
            state_d = StWaitSpace;
          end
        end
      end

      StWaitDrain: begin
        if (drained) begin
          if (type_q == CMD_WEIGHTS) begin
            state_d = StWload;
          end else begin
            state_d = StIload;
            wpend_d = 1'b0;
          end
        end
      end

      StWaitSpace: begin
        if (fifo_has_space) begin
          state_d = StIload;
        end
      end

      StWload: begin
        if (row_fire) begin
          weight_en_d = 1'b1;
          row_in_en_d = cnt_q[CntW-2:0];
          vals_d      = row_vals;
          inds_d      = row_inds;
          ends_d      = row_ends;
          if (cnt_q == LastRow) begin
            cnt_d   = '0;
            state_d = StCgap;
            if (DBUF) begin
              wpend_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StIload: begin
        if (row_fire) begin
          input_en_d = 1'b1;
          vals_d     = row_vals;
          inds_d     = row_inds;
          ends_d     = row_ends;
          // Partials enter only with the first row of the batch.
          if (cnt_q == '0) begin
            partial_en_d = 1'b1;
            partials_d   = row_partials;
          end
          cnt_d   = cnt_q + CntW'(1);
          state_d = StIgap;
        end
      end

      StIgap: begin
        state_d = (cnt_q == rows_q) ? StCgap : StIload;
      end

      StCgap: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q      <= StIdle;
      type_q       <= CMD_WEIGHTS;
      wpend_q      <= 1'b0;
      rows_q       <= '0;
      cnt_q        <= '0;
      weight_en_q  <= 1'b0;
      input_en_q   <= 1'b0;
      partial_en_q <= 1'b0;
      row_in_en_q  <= '0;
      vals_q       <= '0;
      inds_q       <= '0;
      ends_q       <= '0;
      partials_q   <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      wpend_q      <= wpend_d;
      rows_q       <= rows_d;
      cnt_q        <= cnt_d;
      weight_en_q  <= weight_en_d;
      input_en_q   <= input_en_d;
      partial_en_q <= partial_en_d;
      row_in_en_q  <= row_in_en_d;
      vals_q       <= vals_d;
      inds_q       <= inds_d;
      ends_q       <= ends_d;
      partials_q   <= partials_d;
    end
  end

  assign weight_en         = weight_en_q;
  assign input_en          = input_en_q;
  assign partial_en        = partial_en_q;
  assign row_in_en         = row_in_en_q;
  assign vals_in           = vals_q;
  assign inds_in           = inds_q;
  assign ends_in           = ends_q;
  assign array_in_partials = partials_q;

  sat_counter #(
    .CW (CW)
  ) u_out_counter (
    .clk_i   (clk),
    .rst_ni  (nRST),
    .en_i    (out_en),
    .count_o (out_count)
  );

endmodule

// File: tb/tb_sys_arr_load_sequencer.sv
module tb_sys_arr_load_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IND = 2;

  logic clk;
  logic nRST;
  logic cmd_valid1, cmd_valid0;
  logic cmd_type;
  logic [2:0] cmd_rows;
  logic row_valid;
  logic [N*DW-1:0] row_vals;
  logic [N*IND-1:0] row_inds;
  logic [N-1:0] row_ends;
  logic [N*DW-1:0] row_partials;
  logic drained, fifo_has_space, out_en;

  // DBUF=1, CW=4 instance
  logic cmd_ready1, row_ready1, weight_en1, input_en1, partial_en1, busy1;
  logic [1:0] row_in_en1;
  logic [N*DW-1:0] vals_in1, partials1;
  logic [N*IND-1:0] inds_in1;
  logic [N-1:0] ends_in1;
  logic [3:0] out_count1;

  // DBUF=0, CW=16 instance
  logic cmd_ready0, row_ready0, weight_en0, input_en0, partial_en0, busy0;
  logic [1:0] row_in_en0;
  logic [N*DW-1:0] vals_in0, partials0;
  logic [N*IND-1:0] inds_in0;
  logic [N-1:0] ends_in0;
  logic [15:0] out_count0;

  int n_tests = 0;
  int n_fail  = 0;
  int acc;

  localparam logic [N*DW-1:0] P = {32'd4, 32'd3, 32'd2, 32'd1};

  sys_arr_load_sequencer #(.N(N), .DW(DW), .IND(IND), .DBUF(1'b1), .CW(4)) u_dut1 (
    .clk(clk), .nRST(nRST), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_type(cmd_type), .cmd_rows(cmd_rows), .row_valid(row_valid), .row_ready(row_ready1),
    .row_vals(row_vals), .row_inds(row_inds), .row_ends(row_ends), .row_partials(row_partials),
    .drained(drained), .fifo_has_space(fifo_has_space), .out_en(out_en),
    .weight_en(weight_en1), .input_en(input_en1), .partial_en(partial_en1),
    .row_in_en(row_in_en1), .vals_in(vals_in1), .inds_in(inds_in1), .ends_in(ends_in1),
    .array_in_partials(partials1), .busy(busy1), .out_count(out_count1)
  );

  sys_arr_load_sequencer #(.N(N), .DW(DW), .IND(IND), .DBUF(1'b0), .CW(16)) u_dut0 (
    .clk(clk), .nRST(nRST), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_type(cmd_type), .cmd_rows(cmd_rows), .row_valid(row_valid), .row_ready(row_ready0),
    .row_vals(row_vals), .row_inds(row_inds), .row_ends(row_ends), .row_partials(row_partials),
    .drained(drained), .fifo_has_space(fifo_has_space), .out_en(out_en),
    .weight_en(weight_en0), .input_en(input_en0), .partial_en(partial_en0),
    .row_in_en(row_in_en0), .vals_in(vals_in0), .inds_in(inds_in0), .ends_in(ends_in0),
    .array_in_partials(partials0), .busy(busy0), .out_count(out_count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*DW-1:0] mk_vals(input int k);
    logic [N*DW-1:0] v;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = 32'(k * 16 + j + 1);
    return v;
  endfunction

  function automatic logic [N*IND-1:0] mk_inds(input int k);
    logic [N*IND-1:0] v;
    for (int j = 0; j < N; j++) v[j*IND +: IND] = 2'((k + j) % 4);
    return v;
  endfunction

  function automatic logic [N-1:0] mk_ends(input int k);
    logic [N-1:0] one;
    one = 4'b0001;
    return one << k;
  endfunction

  task automatic set_row(input int k);
    row_vals = mk_vals(k);
    row_inds = mk_inds(k);
    row_ends = mk_ends(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; cmd_valid1 = 1'b0; cmd_valid0 = 1'b0; cmd_type = 1'b0; cmd_rows = 3'd0;
    row_valid = 1'b0; row_partials = P; drained = 1'b0; fifo_has_space = 1'b1; out_en = 1'b0;
    set_row(0);
    tick(); tick();
    check("rst_cmd_ready", 256'(cmd_ready1), 256'(1));
    check("rst_busy", 256'(busy1), 256'(0));
    check("rst_out_count", 256'(out_count1), 256'(0));
    check("rst_vals", 256'(vals_in1), 256'(0));
    nRST = 1'b1;

    // Weight tile on the double-buffered instance, continuous stream.
    cmd_valid1 = 1'b1; cmd_type = 1'b0; tick(); cmd_valid1 = 1'b0;
    check("w_busy", 256'(busy1), 256'(1));
    row_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_row(k); tick();
      check("w_en", 256'(weight_en1), 256'(1));
      check("w_row_idx", 256'(row_in_en1), 256'(k));
      check("w_vals", 256'(vals_in1), 256'(mk_vals(k)));
    end
    row_valid = 1'b0; tick();
    check("w_done_en", 256'(weight_en1), 256'(0));
    check("w_done_vals", 256'(vals_in1), 256'(0));
    check("w_hold_inds", 256'(inds_in1), 256'(mk_inds(3)));
    check("w_hold_ends", 256'(ends_in1), 256'(mk_ends(3)));
    check("w_idle", 256'(cmd_ready1), 256'(1));

    // 3-row input batch gated on drain because a tile is pending.
    cmd_valid1 = 1'b1; cmd_type = 1'b1; cmd_rows = 3'd3; tick(); cmd_valid1 = 1'b0;
    row_valid = 1'b1; set_row(0);
    acc = 0;
    repeat (10) begin tick(); acc += int'(input_en1); end
    check("i_gate_drain", 256'(acc), 256'(0));
    drained = 1'b1; tick(); drained = 1'b0;
    check("i_gate_open", 256'(input_en1), 256'(0));
    tick();
    check("i_row0_en", 256'(input_en1), 256'(1));
    check("i_row0_pen", 256'(partial_en1), 256'(1));
    check("i_row0_part", 256'(partials1), 256'(P));
    set_row(1); tick();
    check("i_gap0", 256'(input_en1), 256'(0));
    tick();
    check("i_row1_en", 256'(input_en1), 256'(1));
    check("i_row1_pen", 256'(partial_en1), 256'(0));
    check("i_row1_part", 256'(partials1), 256'(0));
    set_row(2); tick();
    check("i_gap1", 256'(input_en1), 256'(0));
    tick();
    check("i_row2_en", 256'(input_en1), 256'(1));
    tick();
    check("i_gap2", 256'(input_en1), 256'(0));
    check("i_cgap_busy", 256'(cmd_ready1), 256'(0));
    tick();
    check("i_idle", 256'(cmd_ready1), 256'(1));
    row_valid = 1'b0;

    // Single-buffered instance: weight load waits for drain.
    cmd_valid0 = 1'b1; cmd_type = 1'b0; tick(); cmd_valid0 = 1'b0;
    row_valid = 1'b1; set_row(0);
    acc = 0;
    repeat (5) begin tick(); acc += int'(weight_en0); end
    check("w0_gate", 256'(acc), 256'(0));
    drained = 1'b1; tick(); drained = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_row(k); tick();
      check("w0_en", 256'(weight_en0), 256'(1));
      check("w0_row_idx", 256'(row_in_en0), 256'(k));
    end
    row_valid = 1'b0; tick();
    check("w0_idle", 256'(cmd_ready0), 256'(1));

    // Input batch stalled on fifo space.
    fifo_has_space = 1'b0;
    cmd_valid0 = 1'b1; cmd_type = 1'b1; cmd_rows = 3'd1; tick(); cmd_valid0 = 1'b0;
    row_valid = 1'b1; set_row(0);
    acc = 0;
    repeat (3) begin tick(); acc += int'(input_en0); end
    check("sp_stall", 256'(acc), 256'(0));
    check("sp_busy", 256'(busy0), 256'(1));
    fifo_has_space = 1'b1; tick();
    check("sp_open", 256'(input_en0), 256'(0));
    tick();
    check("sp_row_en", 256'(input_en0), 256'(1));
    check("sp_row_pen", 256'(partial_en0), 256'(1));
    check("sp_row_part", 256'(partials0), 256'(P));
    row_valid = 1'b0; tick(); tick();
    check("sp_idle", 256'(cmd_ready0), 256'(1));

    // Row-stream bubble mid weight tile.
    cmd_valid1 = 1'b1; cmd_type = 1'b0; tick(); cmd_valid1 = 1'b0;
    row_valid = 1'b1; set_row(0); tick();
    check("b_row0", 256'(row_in_en1), 256'(0));
    set_row(1); tick();
    check("b_row1", 256'(row_in_en1), 256'(1));
    row_valid = 1'b0;
    repeat (3) begin
      tick();
      check("b_gap_en", 256'(weight_en1), 256'(0));
      check("b_gap_idx", 256'(row_in_en1), 256'(0));
    end
    row_valid = 1'b1; set_row(2); tick();
    check("b_row2_en", 256'(weight_en1), 256'(1));
    check("b_row2", 256'(row_in_en1), 256'(2));
    set_row(3); tick();
    check("b_row3", 256'(row_in_en1), 256'(3));
    row_valid = 1'b0; tick();
    check("b_idle", 256'(cmd_ready1), 256'(1));

    // Empty input batch: CGAP then IDLE, no strobes.
    cmd_valid1 = 1'b1; cmd_type = 1'b1; cmd_rows = 3'd0; tick(); cmd_valid1 = 1'b0;
    check("z_busy", 256'(busy1), 256'(1));
    tick();
    check("z_strobes", 256'({weight_en1, input_en1, partial_en1}), 256'(0));
    check("z_idle", 256'(cmd_ready1), 256'(1));

    // Reset mid-WLOAD (wpend is set from the bubble tile).
    cmd_valid1 = 1'b1; cmd_type = 1'b0; tick(); cmd_valid1 = 1'b0;
    row_valid = 1'b1; set_row(0); tick(); set_row(1); tick();
    nRST = 1'b0; tick(); tick();
    check("r_cmd_ready", 256'(cmd_ready1), 256'(1));
    check("r_strobes", 256'({weight_en1, input_en1, partial_en1}), 256'(0));
    check("r_row_idx", 256'(row_in_en1), 256'(0));
    check("r_inds", 256'(inds_in1), 256'(0));
    check("r_out_count", 256'(out_count1), 256'(0));
    nRST = 1'b1; row_valid = 1'b0;

    // wpend cleared: inputs must not wait for drain.
    cmd_valid1 = 1'b1; cmd_type = 1'b1; cmd_rows = 3'd1; tick(); cmd_valid1 = 1'b0;
    row_valid = 1'b1; tick(); tick();
    check("r_wpend_clear", 256'(input_en1), 256'(1));
    row_valid = 1'b0; tick(); tick();

    // Output counter saturation (CW=4) vs. wide counter.
    out_en = 1'b1;
    repeat (5) tick();
    check("cnt_5", 256'(out_count1), 256'(5));
    check("cnt0_5", 256'(out_count0), 256'(5));
    repeat (16) tick();
    check("cnt_sat", 256'(out_count1), 256'(15));
    check("cnt0_21", 256'(out_count0), 256'(21));
    out_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
